// File: rtl/lfsr_sequencer.sv
// Command controller for a Fibonacci LFSR: latches seed/step count, loads, shifts
// N times (or until the state returns to the seed) and reports completion.
module lfsr_sequencer #(
  parameter int unsigned            WIDTH = 4,
  parameter logic [WIDTH-1:0]       TAPS  = 4'b1100,
  parameter int unsigned            CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] lfsr_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             bit_out,
  output logic             bit_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] seed_q,    seed_d;
  logic [CNT_W-1:0] steps_q,   steps_d;
  logic [WIDTH-1:0] lfsr_q,    lfsr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_vld_q, bit_vld_d;

  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    shifted   = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    cnt_inc   = cnt_q + CNT_W'(1);

    state_d   = state_q;
    seed_d    = seed_q;
    steps_d   = steps_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bit_out_d = bit_out_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bit_vld_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d  = seed;
          steps_d = steps;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          lfsr_d = seed_q;
          if (seed_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // abort wins over any stop condition and freezes lfsr/cnt
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          lfsr_d    = shifted;
          cnt_d     = cnt_inc;
          bit_vld_d = 1'b1;
          bit_out_d = shifted[WIDTH-1];
          busy_d    = 1'b1;
          if (steps_q != '0) begin
            if (cnt_inc == steps_q) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else if (shifted == seed_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (cnt_inc == '1) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      steps_q   <= '0;
      lfsr_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bit_out_q <= 1'b0;
      bit_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      steps_q   <= steps_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bit_out_q <= bit_out_d;
      bit_vld_q <= bit_vld_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign lfsr_out = lfsr_q;
  assign cnt_out  = cnt_q;
  assign bit_out  = bit_out_q;
  assign bit_vld  = bit_vld_q;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Directed bench for lfsr_sequencer; a second instance with a 3-bit counter
// exercises the no-wrap saturation path.
module tb_lfsr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] seed = '0;
  logic [7:0] steps = '0;
  logic       busy, done, err, bit_out, bit_vld;
  logic [3:0] lfsr_out;
  logic [7:0] cnt_out;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic [3:0] seed2 = '0;
  logic [2:0] steps2 = '0;
  logic       busy2, done2, err2, bit_out2, bit_vld2;
  logic [3:0] lfsr_out2;
  logic [2:0] cnt_out2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_sequencer #(.WIDTH(4), .TAPS(4'b1100), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .steps(steps),
    .busy(busy), .done(done), .err(err), .lfsr_out(lfsr_out), .cnt_out(cnt_out),
    .bit_out(bit_out), .bit_vld(bit_vld)
  );

  lfsr_sequencer #(.WIDTH(4), .TAPS(4'b1100), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .seed(seed2), .steps(steps2),
    .busy(busy2), .done(done2), .err(err2), .lfsr_out(lfsr_out2), .cnt_out(cnt_out2),
    .bit_out(bit_out2), .bit_vld(bit_vld2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    total++;
    if ({busy, done, err, bit_out, bit_vld} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, err, bit_out, bit_vld});
    end
    total++;
    if (lfsr_out !== 4'h0 || cnt_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got lfsr=%h cnt=%h exp lfsr=0 cnt=00", lfsr_out, cnt_out);
    end
    #3 rst = 1'b1;
    cyc();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_steps();
    logic [3:0] exp_s [0:2];
    logic       exp_b [0:2];
    exp_s = '{4'b0010, 4'b0100, 4'b1001};
    exp_b = '{1'b0, 1'b0, 1'b1};
    start = 1'b1; seed = 4'b0001; steps = 8'd3;
    cyc();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || cnt_out !== 8'd0) begin
      bad++;
      $display("FAIL steps_accept got busy=%b done=%b err=%b cnt=%0d exp 1 0 0 0", busy, done, err, cnt_out);
    end
    cyc();
    total++;
    if (lfsr_out !== 4'b0001 || bit_vld !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL steps_load got lfsr=%b vld=%b busy=%b exp 0001 0 1", lfsr_out, bit_vld, busy);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (lfsr_out !== exp_s[k] || cnt_out !== 8'(k + 1) || bit_vld !== 1'b1 ||
          bit_out !== exp_b[k] || done !== 1'(k == 2)) begin
        bad++;
        $display("FAIL steps_shift%0d got lfsr=%b cnt=%0d vld=%b bit=%b done=%b exp lfsr=%b cnt=%0d vld=1 bit=%b done=%b",
                 k, lfsr_out, cnt_out, bit_vld, bit_out, done, exp_s[k], k + 1, exp_b[k], k == 2);
      end
    end
    cyc();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || bit_vld !== 1'b0 || lfsr_out !== 4'b1001 || cnt_out !== 8'd3) begin
      bad++;
      $display("FAIL steps_hold got done=%b busy=%b vld=%b lfsr=%b cnt=%0d exp 0 0 0 1001 3",
               done, busy, bit_vld, lfsr_out, cnt_out);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_s [0:14];
    exp_s = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
              4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    start = 1'b1; seed = 4'b0001; steps = 8'd0;
    cyc();
    start = 1'b0;
    cyc();
    for (int k = 0; k < 15; k++) begin
      cyc();
      total++;
      if (lfsr_out !== exp_s[k] || cnt_out !== 8'(k + 1) || done !== 1'(k == 14)) begin
        bad++;
        $display("FAIL wrap_shift%0d got lfsr=%b cnt=%0d done=%b exp lfsr=%b cnt=%0d done=%b",
                 k, lfsr_out, cnt_out, done, exp_s[k], k + 1, k == 14);
      end
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_err got=%b exp=0", err);
    end
    cyc();
    total++;
    if (done !== 1'b0 || lfsr_out !== 4'b0001 || cnt_out !== 8'd15) begin
      bad++;
      $display("FAIL wrap_hold got done=%b lfsr=%b cnt=%0d exp 0 0001 15", done, lfsr_out, cnt_out);
    end
  endtask

  task automatic test_zero_seed();
    start = 1'b1; seed = 4'b0000; steps = 8'd5;
    cyc();
    start = 1'b0;
    cyc();
    total++;
    if (done !== 1'b1 || err !== 1'b1 || cnt_out !== 8'd0 || lfsr_out !== 4'h0 || bit_vld !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done got done=%b err=%b cnt=%0d lfsr=%b vld=%b busy=%b exp 1 1 0 0000 0 0",
               done, err, cnt_out, lfsr_out, bit_vld, busy);
    end
    cyc();
    total++;
    if (done !== 1'b0 || err !== 1'b1 || bit_vld !== 1'b0) begin
      bad++;
      $display("FAIL zero_sticky got done=%b err=%b vld=%b exp 0 1 0", done, err, bit_vld);
    end
  endtask

  task automatic test_start_while_busy();
    start = 1'b1; seed = 4'b0001; steps = 8'd3;
    cyc();
    start = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL busy_errclr got=%b exp=0", err);
    end
    cyc();
    start = 1'b1; seed = 4'b1111; steps = 8'd7;
    cyc();
    start = 1'b0;
    total++;
    if (lfsr_out !== 4'b0010 || cnt_out !== 8'd1) begin
      bad++;
      $display("FAIL busy_ignore got lfsr=%b cnt=%0d exp 0010 1", lfsr_out, cnt_out);
    end
    cyc();
    cyc();
    total++;
    if (done !== 1'b1 || lfsr_out !== 4'b1001 || cnt_out !== 8'd3) begin
      bad++;
      $display("FAIL busy_done got done=%b lfsr=%b cnt=%0d exp 1 1001 3", done, lfsr_out, cnt_out);
    end
    cyc();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; seed = 4'b0001; steps = 8'd10;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bit_vld !== 1'b0 ||
        cnt_out !== 8'd2 || lfsr_out !== 4'b0100) begin
      bad++;
      $display("FAIL abort_idle got busy=%b done=%b err=%b vld=%b cnt=%0d lfsr=%b exp 0 0 0 0 2 0100",
               busy, done, err, bit_vld, cnt_out, lfsr_out);
    end
    cyc();
    total++;
    if (done !== 1'b0 || cnt_out !== 8'd2 || lfsr_out !== 4'b0100) begin
      bad++;
      $display("FAIL abort_hold got done=%b cnt=%0d lfsr=%b exp 0 2 0100", done, cnt_out, lfsr_out);
    end
    start = 1'b1; seed = 4'b0001; steps = 8'd1;
    cyc();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || cnt_out !== 8'd0) begin
      bad++;
      $display("FAIL abort_restart got busy=%b cnt=%0d exp 1 0", busy, cnt_out);
    end
    cyc();
    cyc();
    total++;
    if (done !== 1'b1 || lfsr_out !== 4'b0010 || cnt_out !== 8'd1 || bit_vld !== 1'b1) begin
      bad++;
      $display("FAIL abort_rerun got done=%b lfsr=%b cnt=%0d vld=%b exp 1 0010 1 1", done, lfsr_out, cnt_out, bit_vld);
    end
    cyc();
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; seed = 4'b0001; steps = 8'd10;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    #3 rst = 1'b0;
    #1;
    total++;
    if (lfsr_out !== 4'h0 || cnt_out !== 8'd0 || busy !== 1'b0 || bit_vld !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async got lfsr=%b cnt=%0d busy=%b vld=%b exp 0000 0 0 0", lfsr_out, cnt_out, busy, bit_vld);
    end
    cyc();
    #3 rst = 1'b1;
    cyc();
    cyc();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || lfsr_out !== 4'h0 || cnt_out !== 8'd0) begin
      bad++;
      $display("FAIL midrst_idle got busy=%b done=%b lfsr=%b cnt=%0d exp 0 0 0000 0", busy, done, lfsr_out, cnt_out);
    end
    test_steps();
  endtask

  task automatic test_saturate();
    start2 = 1'b1; seed2 = 4'b0001; steps2 = 3'd0;
    cyc();
    start2 = 1'b0;
    cyc();
    for (int k = 0; k < 6; k++) cyc();
    total++;
    if (done2 !== 1'b0 || busy2 !== 1'b1 || cnt_out2 !== 3'd6) begin
      bad++;
      $display("FAIL sat_pre got done=%b busy=%b cnt=%0d exp 0 1 6", done2, busy2, cnt_out2);
    end
    cyc();
    total++;
    if (done2 !== 1'b1 || err2 !== 1'b1 || cnt_out2 !== 3'd7 || lfsr_out2 !== 4'b1010) begin
      bad++;
      $display("FAIL sat_stop got done=%b err=%b cnt=%0d lfsr=%b exp 1 1 7 1010", done2, err2, cnt_out2, lfsr_out2);
    end
    cyc();
    total++;
    if (done2 !== 1'b0 || err2 !== 1'b1 || cnt_out2 !== 3'd7) begin
      bad++;
      $display("FAIL sat_hold got done=%b err=%b cnt=%0d exp 0 1 7", done2, err2, cnt_out2);
    end
  endtask

  initial begin
    test_reset();
    test_steps();
    test_wrap();
    test_zero_seed();
    test_start_while_busy();
    test_abort();
    test_reset_mid_run();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
